// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } div_state_t;

   function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                     input logic               neg);
      return neg ? -v : v;
   endfunction

   // Magnitude of v; for unsigned operands the value is returned as is.
   function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                    input logic               sgn);
      return cond_neg(v, sgn & v[DIV_WIDTH-1]);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   assign shifted = {rem_in, dvd_msb};
   assign q_bit   = (shifted >= {2'b00, dvs});
   // The partial remainder stays below the divisor, so the top bit never matters here.
   assign diff    = shifted[WIDTH:0] - {1'b0, dvs};
   assign rem_out = q_bit ? diff : shifted[WIDTH:0];

endmodule

// File: rtl/div_multicycle.sv
// Iterative DIV/DIVU unit: one quotient bit per clock, sign fix-up in a final cycle.
//
//  state | meaning
//  IDLE  | waiting for start; divide-by-zero resolved here directly
//  RUN   | WIDTH restoring steps on operand magnitudes
//  FIX   | apply result signs, register quotient/remainder
//  DONE  | one-cycle completion pulse
module div_multicycle
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state, state_d;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_nxt;
   logic [CNT_W-1:0] count;
   logic             q_neg;
   logic             r_neg;
   logic             q_bit;
   logic             last_step;

   assign last_step = (count == CNT_W'(WIDTH - 1));
   assign busy      = (state == RUN) || (state == FIX);
   assign done      = (state == DONE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .dvd_msb (dvd[WIDTH-1]),
      .dvs     (dvs),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
         RUN:  if (last_step) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Quotient bits are shifted into the low end of dvd as the dividend bits leave the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         count       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     dvd   <= abs_val(dividend, is_signed);
                     dvs   <= abs_val(divisor, is_signed);
                     q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     r_neg <= is_signed & dividend[WIDTH-1];
                     rem   <= '0;
                     count <= '0;
                  end
               end
            end
            RUN: begin
               rem   <= rem_nxt;
               dvd   <= {dvd[WIDTH-2:0], q_bit};
               count <= count + 1'b1;
            end
            FIX: begin
               quotient    <= cond_neg(dvd, q_neg);
               remainder   <= cond_neg(rem[WIDTH-1:0], r_neg);
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_multicycle.sv
// Self-checking bench for div_multicycle: vector table, scoreboard, multi-cycle corner sequences.
module tb_div_multicycle;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          due;
      string       nm;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   div_multicycle dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: SV signed division truncates toward zero, remainder takes the dividend sign.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz);
      dbz = 1'b0;
      if (b == 32'd0) begin
         q = '1; r = a; dbz = 1'b1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = '0;
      end else if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, want no pending operation (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, " quotient"}, quotient, e.q);
            check({e.nm, " remainder"}, remainder, e.r);
            check({e.nm, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
            check({e.nm, " done_cycle"}, cyc, e.due);
         end
      end
   end

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: got no done, want done within 60 cycles", nm);
         sb.delete();
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
   endtask

   task automatic scramble();
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic do_op(input vec_t v, input string nm);
      exp_t e;
      @(negedge clk);
      e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.due = cyc + v.lat; e.nm = nm;
      sb.push_back(e);
      drive(v.a, v.b, v.sgn);
      @(negedge clk);
      scramble();
      check({nm, " busy_c1"}, 32'(busy), 32'(v.lat != 1));
      wait_idle(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      int c0;

      tbl.push_back('{32'd100,        32'd7,          1'b0, 32'd14,        32'd2,         1'b0, 34});
      tbl.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34});
      tbl.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,         1'b0, 34});
      tbl.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, 34});
      tbl.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1, 1});
      tbl.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, 34});
      tbl.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 34});
      tbl.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC, 32'd1,         1'b0, 34});
      tbl.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1});
      tbl.push_back('{32'd0,          32'd5,          1'b1, 32'd0,         32'd0,         1'b0, 34});
      tbl.push_back('{32'd3,          32'd10,         1'b0, 32'd0,         32'd3,         1'b0, 34});
      tbl.push_back('{32'h1234_5678,  32'h0000_1000,  1'b0, 32'h0001_2345, 32'h0000_0678, 1'b0, 34});
      for (int i = 0; i < 8; i++) begin
         v.a = $urandom;
         v.b = (i == 3) ? 32'($urandom_range(1, 15)) : $urandom >> $urandom_range(0, 31);
         v.sgn = 1'(i % 2);
         model(v.a, v.b, v.sgn, v.q, v.r, v.dbz);
         v.lat = v.dbz ? 1 : 34;
         tbl.push_back(v);
      end

      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset div_by_zero", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

      // Busy profile of a full-length divide.
      @(negedge clk);
      c0 = cyc;
      sb.push_back('{32'd14, 32'd2, 1'b0, c0 + 34, "busy_seq"});
      drive(32'd100, 32'd7, 1'b0);
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k == 1) scramble();
         check($sformatf("busy_seq busy_c%0d", k), 32'(busy), 32'(k <= 33));
      end
      wait_idle("busy_seq");

      // Start while busy and start during DONE are both ignored.
      @(negedge clk);
      c0 = cyc;
      sb.push_back('{32'd14, 32'd2, 1'b0, c0 + 34, "ignore_seq"});
      drive(32'd100, 32'd7, 1'b0);
      for (int k = 1; k <= 37; k++) begin
         @(negedge clk);
         if (k == 1 || k == 6 || k == 35) scramble();
         if (k == 5 || k == 34) drive(32'd9, 32'd3, 1'b0);
      end
      check("ignore_seq busy_after", 32'(busy), 32'd0);
      check("ignore_seq held_quotient", quotient, 32'd14);
      check("ignore_seq held_remainder", remainder, 32'd2);
      wait_idle("ignore_seq");

      // Reset mid-operation aborts without a done pulse.
      @(negedge clk);
      drive(32'd100, 32'd7, 1'b0);
      @(negedge clk);
      scramble();
      repeat (9) @(negedge clk);
      check("abort busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort quotient", quotient, 32'd0);
      check("abort remainder", remainder, 32'd0);
      check("abort div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort idle_after", 32'(busy), 32'd0);
      do_op('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34}, "after_abort");

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
